// File: rtl/cext_aligner.sv
// Halfword aligner and RV32C expander between the icache response and fetch.
// Optional macro CEXT_ILLEGAL_INFO_EN adds illegal_o and forwards raw illegal encodings.
module cext_aligner #(
  parameter int unsigned XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr_un_i,
  input  logic            instr_valid_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            flush_i,
  input  logic            hold_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  output logic            is_comp_o,
  output logic [XLEN-1:0] pc_aligned_o,
  output logic            bubble_o,
`ifdef CEXT_ILLEGAL_INFO_EN
  output logic            illegal_o,
`endif
  output logic            stall_o
);

  typedef enum logic {
    ST_NORMAL   = 1'b0,
    ST_STRADDLE = 1'b1
  } state_e;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPC_OP};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_STORE};
  endfunction

  // b holds branch offset bits [12:1]
  function automatic logic [31:0] enc_b(input logic [11:0] b, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {b[11], b[9:4], 5'd0, rs1, f3, b[3:0], b[10], OPC_BRANCH};
  endfunction

  // j holds jump offset bits [20:1]
  function automatic logic [31:0] enc_j(input logic [19:0] j, input logic [4:0] rd);
    return {j[19], j[9:0], j[10], j[18:11], rd, OPC_JAL};
  endfunction

  // Returns {illegal, expanded instruction}.
  function automatic logic [32:0] expand(input logic [15:0] c);
    logic [31:0] o;
    logic        ill;
    logic [4:0]  rd;
    logic [4:0]  rs2;
    logic [4:0]  rdp;
    logic [4:0]  rs1p;
    logic [5:0]  imm6;
    logic [11:0] sx6;
    logic [11:0] imm12;
    logic [19:0] jimm;
    logic [11:0] bimm;
    o     = 32'h0000_0000;
    ill   = 1'b0;
    rd    = c[11:7];
    rs2   = c[6:2];
    rdp   = {2'b01, c[4:2]};
    rs1p  = {2'b01, c[9:7]};
    imm6  = {c[12], c[6:2]};
    sx6   = {{6{c[12]}}, imm6};
    imm12 = 12'h000;
    jimm  = {{9{c[12]}}, c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3]};
    bimm  = {{4{c[12]}}, c[12], c[6:5], c[2], c[11:10], c[4:3]};
    case (c[1:0])
      2'b00: begin
        case (c[15:13])
          3'b000: begin
            imm12 = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00};
            if (imm12 == 12'h000) ill = 1'b1;
            else                  o   = enc_i(imm12, 5'd2, 3'b000, rdp, OPC_OP_IMM);
          end
          3'b010:  o = enc_i({5'b00000, c[5], c[12:10], c[6], 2'b00}, rs1p, 3'b010, rdp, OPC_LOAD);
          3'b110:  o = enc_s({5'b00000, c[5], c[12:10], c[6], 2'b00}, rdp, rs1p);
          default: ill = 1'b1;
        endcase
      end
      2'b01: begin
        case (c[15:13])
          3'b000: o = enc_i(sx6, rd, 3'b000, rd, OPC_OP_IMM);
          3'b001: o = enc_j(jimm, 5'd1);
          3'b010: o = enc_i(sx6, 5'd0, 3'b000, rd, OPC_OP_IMM);
          3'b011: begin
            if (rd == 5'd2) begin
              imm12 = {{2{c[12]}}, c[12], c[4:3], c[5], c[2], c[6], 4'b0000};
              if (imm12 == 12'h000) ill = 1'b1;
              else                  o   = enc_i(imm12, 5'd2, 3'b000, 5'd2, OPC_OP_IMM);
            end else if (imm6 == 6'd0) begin
              ill = 1'b1;
            end else begin
              o = {{14{c[12]}}, imm6, rd, OPC_LUI};
            end
          end
          3'b100: begin
            case (c[11:10])
              2'b00: begin
                if (c[12]) ill = 1'b1;
                else       o   = enc_i({7'b0000000, c[6:2]}, rs1p, 3'b101, rs1p, OPC_OP_IMM);
              end
              2'b01: begin
                if (c[12]) ill = 1'b1;
                else       o   = enc_i({7'b0100000, c[6:2]}, rs1p, 3'b101, rs1p, OPC_OP_IMM);
              end
              2'b10: o = enc_i(sx6, rs1p, 3'b111, rs1p, OPC_OP_IMM);
              default: begin
                if (c[12]) begin
                  ill = 1'b1;
                end else begin
                  case (c[6:5])
                    2'b00:   o = enc_r(7'b0100000, rdp, rs1p, 3'b000, rs1p);
                    2'b01:   o = enc_r(7'b0000000, rdp, rs1p, 3'b100, rs1p);
                    2'b10:   o = enc_r(7'b0000000, rdp, rs1p, 3'b110, rs1p);
                    default: o = enc_r(7'b0000000, rdp, rs1p, 3'b111, rs1p);
                  endcase
                end
              end
            endcase
          end
          3'b101:  o = enc_j(jimm, 5'd0);
          3'b110:  o = enc_b(bimm, rs1p, 3'b000);
          default: o = enc_b(bimm, rs1p, 3'b001);
        endcase
      end
      2'b10: begin
        case (c[15:13])
          3'b000: begin
            if (c[12]) ill = 1'b1;
            else       o   = enc_i({7'b0000000, c[6:2]}, rd, 3'b001, rd, OPC_OP_IMM);
          end
          3'b010: begin
            if (rd == 5'd0) ill = 1'b1;
            else            o   = enc_i({4'b0000, c[3:2], c[12], c[6:4], 2'b00}, 5'd2, 3'b010, rd, OPC_LOAD);
          end
          3'b100: begin
            if (!c[12]) begin
              if (rs2 != 5'd0)     o   = enc_r(7'b0000000, rs2, 5'd0, 3'b000, rd);
              else if (rd == 5'd0) ill = 1'b1;
              else                 o   = enc_i(12'h000, rd, 3'b000, 5'd0, OPC_JALR);
            end else begin
              if (rs2 != 5'd0)     o = enc_r(7'b0000000, rs2, rd, 3'b000, rd);
              else if (rd == 5'd0) o = 32'h0010_0073;
              else                 o = enc_i(12'h000, rd, 3'b000, 5'd1, OPC_JALR);
            end
          end
          3'b110:  o = enc_s({4'b0000, c[8:7], c[12:9], 2'b00}, rs2, 5'd2);
          default: ill = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase
    return {ill, o};
  endfunction

  state_e          state_q;
  state_e          state_d;
  logic [15:0]     lo_buf_q;
  logic [15:0]     lo_buf_d;
  logic [XLEN-1:0] lo_pc_q;
  logic [XLEN-1:0] lo_pc_d;
  logic [15:0]     hw_s;
  logic            hw_comp_s;
  logic [32:0]     exp_s;
  logic [31:0]     ill_instr_s;

  assign hw_s      = pc_i[1] ? instr_un_i[31:16] : instr_un_i[15:0];
  assign hw_comp_s = (hw_s[1:0] != 2'b11);
  assign exp_s     = expand(hw_s);

`ifdef CEXT_ILLEGAL_INFO_EN
  assign ill_instr_s = {16'h0000, hw_s};
  assign illegal_o   = !flush_i && (state_q == ST_NORMAL) && instr_valid_i
                       && hw_comp_s && exp_s[32];
`else
  assign ill_instr_s = 32'h0000_0000;
`endif

  // Output selection and next-state; defaults describe a NOP bubble.
  always_comb begin
    state_d      = state_q;
    lo_buf_d     = lo_buf_q;
    lo_pc_d      = lo_pc_q;
    instr_o      = NOP_INSTR;
    instr_pc_o   = pc_i;
    pc_aligned_o = pc_i;
    is_comp_o    = 1'b0;
    bubble_o     = 1'b1;
    stall_o      = 1'b0;
    if (flush_i) begin
      state_d  = ST_NORMAL;
      lo_buf_d = 16'h0000;
      lo_pc_d  = {XLEN{1'b0}};
    end else if (state_q == ST_STRADDLE) begin
      if (instr_valid_i) begin
        instr_o      = {instr_un_i[15:0], lo_buf_q};
        instr_pc_o   = lo_pc_q;
        pc_aligned_o = lo_pc_q;
        bubble_o     = 1'b0;
        state_d      = ST_NORMAL;
      end else begin
        stall_o = 1'b1;
      end
    end else if (instr_valid_i) begin
      if (hw_comp_s) begin
        instr_o   = exp_s[32] ? ill_instr_s : exp_s[31:0];
        is_comp_o = 1'b1;
        bubble_o  = 1'b0;
      end else if (!pc_i[1]) begin
        instr_o  = instr_un_i;
        bubble_o = 1'b0;
      end else begin
        // Upper half starts a 32-bit instruction: park it and step fetch to the next word.
        state_d   = ST_STRADDLE;
        lo_buf_d  = hw_s;
        lo_pc_d   = pc_i;
        is_comp_o = 1'b1;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and half-instruction buffer; flush overrides hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_NORMAL;
      lo_buf_q <= 16'h0000;
      lo_pc_q  <= {XLEN{1'b0}};
    end else if (flush_i || !hold_i) begin
      state_q  <= state_d;
      lo_buf_q <= lo_buf_d;
      lo_pc_q  <= lo_pc_d;
    end else begin
      state_q  <= state_q;
      lo_buf_q <= lo_buf_q;
      lo_pc_q  <= lo_pc_q;
    end
  end

endmodule

// File: tb/tb_cext_aligner.sv
// Self-checking bench for cext_aligner: directed vector table, reset corner, random vs reference model.
module tb_cext_aligner;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_un_i;
  logic        instr_valid_i;
  logic [31:0] pc_i;
  logic        flush_i;
  logic        hold_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        is_comp_o;
  logic [31:0] pc_aligned_o;
  logic        bubble_o;
  logic        stall_o;
`ifdef CEXT_ILLEGAL_INFO_EN
  logic        illegal_o;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cext_aligner dut (
    .clk          (clk),
    .rst          (rst),
    .instr_un_i   (instr_un_i),
    .instr_valid_i(instr_valid_i),
    .pc_i         (pc_i),
    .flush_i      (flush_i),
    .hold_i       (hold_i),
    .instr_o      (instr_o),
    .instr_pc_o   (instr_pc_o),
    .is_comp_o    (is_comp_o),
    .pc_aligned_o (pc_aligned_o),
    .bubble_o     (bubble_o),
`ifdef CEXT_ILLEGAL_INFO_EN
    .illegal_o    (illegal_o),
`endif
    .stall_o      (stall_o)
  );

  typedef struct packed {
    logic        v;
    logic        fl;
    logic        hd;
    logic [31:0] pc;
    logic [31:0] w;
    logic [98:0] exp;
  } vec_t;

  typedef struct packed {
    logic [15:0] hw;
    logic [31:0] pc;
  } pend_t;

  vec_t  tbl[$];
  pend_t pq[$];

  function automatic logic [98:0] pack(logic [31:0] ins, logic [31:0] ipc, logic comp,
                                       logic [31:0] pal, logic bub, logic stl);
    return {ins, ipc, comp, pal, bub, stl};
  endfunction

  function automatic logic [98:0] outs();
    return pack(instr_o, instr_pc_o, is_comp_o, pc_aligned_o, bubble_o, stall_o);
  endfunction

  function automatic vec_t mk(logic v, logic fl, logic hd, logic [31:0] pc, logic [31:0] w,
                              logic [31:0] ins, logic [31:0] ipc, logic comp,
                              logic [31:0] pal, logic bub, logic stl);
    vec_t t;
    t.v = v; t.fl = fl; t.hd = hd; t.pc = pc; t.w = w;
    t.exp = pack(ins, ipc, comp, pal, bub, stl);
    return t;
  endfunction

  task automatic check(input string nm, input logic [98:0] act, input logic [98:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // ---------------- reference expander (arithmetic immediates) ----------------
  function automatic int bt(logic [15:0] c, int i);
    return int'(c[i]);
  endfunction

  function automatic logic [31:0] e_i(int imm, logic [4:0] rs1, int f3, logic [4:0] rd, logic [6:0] op);
    logic [31:0] x;
    x = imm;
    return {x[11:0], rs1, f3[2:0], rd, op};
  endfunction

  function automatic logic [31:0] e_s(int imm, logic [4:0] rs2, logic [4:0] rs1);
    logic [31:0] x;
    x = imm;
    return {x[11:5], rs2, rs1, 3'b010, x[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] e_b(int imm, logic [4:0] rs1, int f3);
    logic [31:0] x;
    x = imm;
    return {x[12], x[10:5], 5'd0, rs1, f3[2:0], x[4:1], x[11], 7'h63};
  endfunction

  function automatic logic [31:0] e_j(int imm, logic [4:0] rd);
    logic [31:0] x;
    x = imm;
    return {x[20], x[10:1], x[11], x[19:12], rd, 7'h6F};
  endfunction

  function automatic logic [31:0] e_r(int f7, logic [4:0] rs2, logic [4:0] rs1, int f3, logic [4:0] rd);
    return {f7[6:0], rs2, rs1, f3[2:0], rd, 7'h33};
  endfunction

  function automatic logic [32:0] ref_expand(logic [15:0] c);
    logic [31:0] r;
    logic        ill;
    logic [4:0]  rd, rs2, rdp, rs1p;
    logic [31:0] ux;
    int imm6, off, f3, sel;
    r = 32'h0; ill = 1'b0;
    rd = c[11:7]; rs2 = c[6:2];
    rdp  = 5'd8 + {2'b00, c[4:2]};
    rs1p = 5'd8 + {2'b00, c[9:7]};
    imm6 = int'(c[6:2]) - 32 * bt(c, 12);
    f3   = int'(c[15:13]);
    sel  = int'(c[6:5]);
    case (c[1:0])
      2'b00: begin
        off = 4*bt(c,6) + 8*int'(c[12:10]) + 64*bt(c,5);
        if (f3 == 0) begin
          off = 4*bt(c,6) + 8*bt(c,5) + 16*bt(c,11) + 32*bt(c,12) + 64*int'(c[10:7]);
          if (off == 0) ill = 1'b1; else r = e_i(off, 5'd2, 0, rdp, 7'h13);
        end else if (f3 == 2) r = e_i(off, rs1p, 2, rdp, 7'h03);
        else if (f3 == 6) r = e_s(off, rdp, rs1p);
        else ill = 1'b1;
      end
      2'b01: begin
        off = 2*int'(c[5:3]) + 16*bt(c,11) + 32*bt(c,2) + 64*bt(c,7) + 128*bt(c,6)
              + 256*int'(c[10:9]) + 1024*bt(c,8) - 2048*bt(c,12);
        case (f3)
          0: r = e_i(imm6, rd, 0, rd, 7'h13);
          1: r = e_j(off, 5'd1);
          2: r = e_i(imm6, 5'd0, 0, rd, 7'h13);
          3: begin
            if (rd == 5'd2) begin
              off = 16*bt(c,6) + 32*bt(c,2) + 64*bt(c,5) + 128*int'(c[4:3]) - 512*bt(c,12);
              if (off == 0) ill = 1'b1; else r = e_i(off, 5'd2, 0, 5'd2, 7'h13);
            end else if (imm6 == 0) ill = 1'b1;
            else begin
              ux = imm6;
              r = {ux[19:0], rd, 7'h37};
            end
          end
          4: begin
            if (c[11:10] == 2'b10) r = e_i(imm6, rs1p, 7, rs1p, 7'h13);
            else if (c[12]) ill = 1'b1;
            else if (c[11:10] == 2'b00) r = e_i(int'(c[6:2]), rs1p, 5, rs1p, 7'h13);
            else if (c[11:10] == 2'b01) r = e_i(1024 + int'(c[6:2]), rs1p, 5, rs1p, 7'h13);
            else r = e_r((sel == 0) ? 32 : 0, rdp, rs1p, (sel == 0) ? 0 : (sel == 1) ? 4 : (sel == 2) ? 6 : 7, rs1p);
          end
          5: r = e_j(off, 5'd0);
          default: begin
            off = 2*int'(c[4:3]) + 8*int'(c[11:10]) + 32*bt(c,2) + 64*int'(c[6:5]) - 256*bt(c,12);
            r = e_b(off, rs1p, (f3 == 6) ? 0 : 1);
          end
        endcase
      end
      2'b10: begin
        if (f3 == 0) begin
          if (c[12]) ill = 1'b1; else r = e_i(int'(c[6:2]), rd, 1, rd, 7'h13);
        end else if (f3 == 2) begin
          off = 4*int'(c[6:4]) + 32*bt(c,12) + 64*int'(c[3:2]);
          if (rd == 5'd0) ill = 1'b1; else r = e_i(off, 5'd2, 2, rd, 7'h03);
        end else if (f3 == 4) begin
          if (rs2 != 5'd0) r = e_r(0, rs2, c[12] ? rd : 5'd0, 0, rd);
          else if (c[12]) r = (rd == 5'd0) ? 32'h0010_0073 : e_i(0, rd, 0, 5'd1, 7'h67);
          else if (rd == 5'd0) ill = 1'b1;
          else r = e_i(0, rd, 0, 5'd0, 7'h67);
        end else if (f3 == 6) begin
          r = e_s(4*int'(c[12:9]) + 64*int'(c[8:7]), rs2, 5'd2);
        end else ill = 1'b1;
      end
      default: ill = 1'b1;
    endcase
`ifdef CEXT_ILLEGAL_INFO_EN
    if (ill) r = {16'h0000, c};
`else
    if (ill) r = 32'h0000_0000;
`endif
    return {ill, r};
  endfunction

  // ---------------- reference aligner: a queue holds the parked low half ----------------
  function automatic logic [98:0] model_out(logic v, logic [31:0] w, logic [31:0] pc, logic fl);
    logic [15:0] hw;
    logic [32:0] ex;
    hw = pc[1] ? w[31:16] : w[15:0];
    if (fl) return pack(NOP, pc, 1'b0, pc, 1'b1, 1'b0);
    if (pq.size() != 0) begin
      if (v) return pack({w[15:0], pq[0].hw}, pq[0].pc, 1'b0, pq[0].pc, 1'b0, 1'b0);
      return pack(NOP, pc, 1'b0, pc, 1'b1, 1'b1);
    end
    if (!v) return pack(NOP, pc, 1'b0, pc, 1'b1, 1'b0);
    if (hw[1:0] != 2'b11) begin
      ex = ref_expand(hw);
      return pack(ex[31:0], pc, 1'b1, pc, 1'b0, 1'b0);
    end
    if (!pc[1]) return pack(w, pc, 1'b0, pc, 1'b0, 1'b0);
    return pack(NOP, pc, 1'b1, pc, 1'b1, 1'b0);
  endfunction

  task automatic model_step();
    logic [15:0] hw;
    pend_t p;
    hw = pc_i[1] ? instr_un_i[31:16] : instr_un_i[15:0];
    if (rst || flush_i) pq.delete();
    else if (hold_i) begin end
    else if (pq.size() != 0) begin
      if (instr_valid_i) void'(pq.pop_front());
    end else if (instr_valid_i && pc_i[1] && hw[1:0] == 2'b11) begin
      p.hw = hw; p.pc = pc_i;
      pq.push_back(p);
    end
  endtask

  task automatic drive(logic v, logic fl, logic hd, logic [31:0] pc, logic [31:0] w);
    instr_valid_i = v; flush_i = fl; hold_i = hd; pc_i = pc; instr_un_i = w;
  endtask

  initial begin
    vec_t t;
    logic [98:0] exp;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h0000_0000);
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs", outs(), pack(NOP, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b1, 1'b0));
    rst = 1'b0;

    // {valid, flush, hold, pc, word} -> {instr, instr_pc, is_comp, pc_aligned, bubble, stall}
    tbl.push_back(mk(0,0,0,32'h8000_0000,32'h0000_0000, NOP,          32'h8000_0000,0,32'h8000_0000,1,0));
    tbl.push_back(mk(1,0,0,32'h8000_0000,32'h0000_0085, 32'h0010_8093,32'h8000_0000,1,32'h8000_0000,0,0));
    tbl.push_back(mk(1,0,0,32'h8000_0002,32'h852E_0000, 32'h00B0_0533,32'h8000_0002,1,32'h8000_0002,0,0));
    tbl.push_back(mk(1,0,0,32'h8000_0100,32'h0010_0093, 32'h0010_0093,32'h8000_0100,0,32'h8000_0100,0,0));
    tbl.push_back(mk(1,0,0,32'h8000_0002,32'h0093_0085, NOP,          32'h8000_0002,1,32'h8000_0002,1,0));
    tbl.push_back(mk(1,0,0,32'h8000_0004,32'hABCD_0010, 32'h0010_0093,32'h8000_0002,0,32'h8000_0002,0,0));
    tbl.push_back(mk(1,0,0,32'h8000_0002,32'h0093_0085, NOP,          32'h8000_0002,1,32'h8000_0002,1,0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,0,0,32'h8000_0004,32'hABCD_0010, NOP,        32'h8000_0004,0,32'h8000_0004,1,1));
    tbl.push_back(mk(1,0,0,32'h8000_0004,32'hABCD_0010, 32'h0010_0093,32'h8000_0002,0,32'h8000_0002,0,0));
    tbl.push_back(mk(1,0,0,32'h8000_0002,32'h0093_0085, NOP,          32'h8000_0002,1,32'h8000_0002,1,0));
    tbl.push_back(mk(1,1,0,32'h8000_0004,32'hABCD_0010, NOP,          32'h8000_0004,0,32'h8000_0004,1,0));
    tbl.push_back(mk(1,0,0,32'h8000_0100,32'h0010_0093, 32'h0010_0093,32'h8000_0100,0,32'h8000_0100,0,0));
    tbl.push_back(mk(1,0,0,32'h8000_0000,32'h0000_0000, 32'h0000_0000,32'h8000_0000,1,32'h8000_0000,0,0));
    tbl.push_back(mk(1,0,1,32'h8000_0002,32'h0093_0085, NOP,          32'h8000_0002,1,32'h8000_0002,1,0));
    tbl.push_back(mk(1,0,0,32'h8000_0004,32'h0000_0085, 32'h0010_8093,32'h8000_0004,1,32'h8000_0004,0,0));
    tbl.push_back(mk(1,0,0,32'h8000_0002,32'h0093_0085, NOP,          32'h8000_0002,1,32'h8000_0002,1,0));
    tbl.push_back(mk(1,0,1,32'h8000_0004,32'hABCD_0010, 32'h0010_0093,32'h8000_0002,0,32'h8000_0002,0,0));
    tbl.push_back(mk(1,0,1,32'h8000_0004,32'hABCD_0010, 32'h0010_0093,32'h8000_0002,0,32'h8000_0002,0,0));
    tbl.push_back(mk(1,1,1,32'h8000_0004,32'hABCD_0010, NOP,          32'h8000_0004,0,32'h8000_0004,1,0));
    tbl.push_back(mk(1,0,0,32'h8000_0100,32'h0010_0093, 32'h0010_0093,32'h8000_0100,0,32'h8000_0100,0,0));
    tbl.push_back(mk(1,0,0,32'hFFFF_FFFE,32'h0093_1234, NOP,          32'hFFFF_FFFE,1,32'hFFFF_FFFE,1,0));
    tbl.push_back(mk(1,0,0,32'h0000_0000,32'h5678_0010, 32'h0010_0093,32'hFFFF_FFFE,0,32'hFFFF_FFFE,0,0));
    tbl.push_back(mk(1,0,0,32'h8000_0000,32'h0000_9002, 32'h0010_0073,32'h8000_0000,1,32'h8000_0000,0,0));
    tbl.push_back(mk(1,0,0,32'h8000_0002,32'hBFFD_0000, 32'hFFFF_F06F,32'h8000_0002,1,32'h8000_0002,0,0));

    foreach (tbl[i]) begin
      t = tbl[i];
      drive(t.v, t.fl, t.hd, t.pc, t.w);
      #1;
      check($sformatf("vec[%0d]", i), outs(), t.exp);
      @(posedge clk);
      @(negedge clk);
    end

    // Reset asserted mid-straddle: bubble at once, no stall, NORMAL afterwards.
    drive(1'b1, 1'b0, 1'b0, 32'h8000_0002, 32'h0093_0085);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h8000_0004, 32'hABCD_0010);
    #1;
    check("straddle_wait_stall", outs(), pack(NOP, 32'h8000_0004, 1'b0, 32'h8000_0004, 1'b1, 1'b1));
    rst = 1'b1;
    #1;
    check("rst_mid_straddle", outs(), pack(NOP, 32'h8000_0004, 1'b0, 32'h8000_0004, 1'b1, 1'b0));
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h8000_0100, 32'h0010_0093);
    #1;
    check("after_rst_normal", outs(), pack(32'h0010_0093, 32'h8000_0100, 1'b0, 32'h8000_0100, 1'b0, 1'b0));
    @(posedge clk);
    @(negedge clk);

    // Random traffic against the reference model (model state starts empty after reset).
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    pq.delete();
    for (int n = 0; n < 4000; n++) begin
      drive(($urandom % 4) != 0, ($urandom % 16) == 0, ($urandom % 5) == 0,
            $urandom & 32'hFFFF_FFFE, $urandom);
      #1;
      exp = model_out(instr_valid_i, instr_un_i, pc_i, flush_i);
      check($sformatf("rnd[%0d]", n), outs(), exp);
      @(posedge clk);
      model_step();
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
